// File: rtl/bitmap_responder.sv
// bitmap_responder: serves VGA pixel requests from a 16-bit Avalon-MM frame store; one-word cache when BITMAP_RESP_CACHE_EN is defined
module bitmap_responder (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sdram_grab,
   input  logic [22:0] sdram_addr,
   output logic        sdram_draw,
   output logic [7:0]  bitmap_intensity,
   output logic [9:0]  sdram_x,
   output logic [9:0]  sdram_y,
   output logic        mem_read,
   output logic [18:0] mem_address,
   input  logic        mem_waitrequest,
   input  logic [15:0] mem_readdata,
   input  logic        mem_readdatavalid,
   input  logic        cache_flush,
   output logic        overrun
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
   state_t      state_q, state_d;
   logic [9:0]  x_q, x_d, y_q, y_d, sx_q, sx_d, sy_q, sy_d;
   logic [7:0]  pix_q, pix_d, int_q, int_d;
   logic        draw_q, draw_d, rd_q, rd_d, ovr_q, ovr_d;
   logic [18:0] addr_q, addr_d;
   logic [9:0]  ax, ay;
   logic        in_range, hit, cache_load;
   logic [7:0]  hit_byte;
   logic        unused_addr;
   assign ax          = sdram_addr[9:0];
   assign ay          = sdram_addr[19:10];
   assign unused_addr = &{1'b0, sdram_addr[22:20]};
   assign in_range    = (ax < 10'd640) && (ay < 10'd480);
   assign cache_load  = (state_q == WAIT) && mem_readdatavalid;
`ifdef BITMAP_RESP_CACHE_EN
   logic [18:0] tag_q;
   logic [15:0] cdata_q;
   logic        cvalid_q;
   // a flush on the same edge as a request forces that request to miss
   assign hit      = cvalid_q && !cache_flush && (tag_q == {ay, ax[9:1]});
   assign hit_byte = ax[0] ? cdata_q[15:8] : cdata_q[7:0];
   // one-word cache: refilled by every completed read, a flush invalidates (flush wins over a refill)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_q    <= '0;
         cdata_q  <= '0;
         cvalid_q <= 1'b0;
      end else begin
         tag_q    <= cache_load ? addr_q : tag_q;
         cdata_q  <= cache_load ? mem_readdata : cdata_q;
         cvalid_q <= cache_flush ? 1'b0 : (cache_load ? 1'b1 : cvalid_q);
      end
   end
`else
   logic unused_flush;
   assign hit          = 1'b0;
   assign hit_byte     = 8'h00;
   assign unused_flush = &{1'b0, cache_flush};
`endif
   // state and output registers; all outputs come straight from flops so reset release cannot glitch them
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         pix_q   <= '0;
         draw_q  <= 1'b0;
         int_q   <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         pix_q   <= pix_d;
         draw_q  <= draw_d;
         int_q   <= int_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         ovr_q   <= ovr_d;
      end
   end
   // next state: accept in IDLE, read through REQ/WAIT on a miss, publish the pixel when leaving RESP
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      pix_d   = pix_q;
      draw_d  = 1'b0;
      int_d   = int_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      ovr_d   = ovr_q | (sdram_grab && (state_q != IDLE));
      case (state_q)
         IDLE: if (sdram_grab) begin
            x_d = ax;
            y_d = ay;
            if (!in_range || hit) begin
               pix_d   = in_range ? hit_byte : 8'h00;
               state_d = RESP;
            end else begin
               rd_d    = 1'b1;
               addr_d  = {ay, ax[9:1]};
               state_d = REQ;
            end
         end
         REQ: if (!mem_waitrequest) begin
            rd_d    = 1'b0;
            state_d = WAIT;
         end
         WAIT: if (mem_readdatavalid) begin
            pix_d   = x_q[0] ? mem_readdata[15:8] : mem_readdata[7:0];
            state_d = RESP;
         end
         RESP: begin
            draw_d  = 1'b1;
            int_d   = pix_q;
            sx_d    = x_q;
            sy_d    = y_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign sdram_draw       = draw_q;
   assign bitmap_intensity = int_q;
   assign sdram_x          = sx_q;
   assign sdram_y          = sy_q;
   assign mem_read         = rd_q;
   assign mem_address      = addr_q;
   assign overrun          = ovr_q;
endmodule

// File: tb/tb_bitmap_responder.sv
// tb_bitmap_responder: directed bench for bitmap_responder (cache expectations follow BITMAP_RESP_CACHE_EN)
module tb_bitmap_responder;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sdram_grab = 1'b0;
   logic [22:0] sdram_addr = '0;
   logic        sdram_draw;
   logic [7:0]  bitmap_intensity;
   logic [9:0]  sdram_x, sdram_y;
   logic        mem_read;
   logic [18:0] mem_address;
   logic        mem_waitrequest = 1'b1;
   logic [15:0] mem_readdata = '0;
   logic        mem_readdatavalid = 1'b0;
   logic        cache_flush = 1'b0;
   logic        overrun;
   int          n_chk = 0, n_err = 0, draw_cnt = 0, rd_cnt = 0, db, rb;

   bitmap_responder dut (
      .clk(clk), .reset_n(reset_n), .sdram_grab(sdram_grab), .sdram_addr(sdram_addr),
      .sdram_draw(sdram_draw), .bitmap_intensity(bitmap_intensity), .sdram_x(sdram_x), .sdram_y(sdram_y),
      .mem_read(mem_read), .mem_address(mem_address), .mem_waitrequest(mem_waitrequest),
      .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
      .cache_flush(cache_flush), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sdram_draw) draw_cnt++;
      if (mem_read) rd_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {sdram_draw, bitmap_intensity, sdram_x, sdram_y, mem_read, mem_address, overrun}, 64'd0);
   endtask

   task automatic grab(input logic [9:0] y, input logic [9:0] x, input logic flush);
      sdram_addr = {3'b000, y, x};
      sdram_grab = 1'b1;
      cache_flush = flush;
      @(posedge clk);
      #1 sdram_grab = 1'b0;
      cache_flush = 1'b0;
   endtask

   task automatic mem_serve(input int waits, input logic [15:0] data);
      repeat (waits) @(posedge clk);
      #1 chk("rd_held", mem_read, 1'b1);
      mem_waitrequest = 1'b0;
      @(posedge clk);
      #1 mem_waitrequest = 1'b1;
      @(negedge clk) chk("rd_drop", mem_read, 1'b0);
      @(posedge clk);
      #1 mem_readdatavalid = 1'b1;
      mem_readdata = data;
      @(posedge clk);
      #1 mem_readdatavalid = 1'b0;
   endtask

   task automatic expect_draw(input string tag, input logic [7:0] i, input logic [9:0] x, input logic [9:0] y);
      @(negedge clk) chk({tag, "_early"}, sdram_draw, 1'b0);
      @(negedge clk) chk({tag, "_draw"}, sdram_draw, 1'b1);
      chk({tag, "_int"}, bitmap_intensity, i);
      chk({tag, "_x"}, sdram_x, x);
      chk({tag, "_y"}, sdram_y, y);
      @(negedge clk) chk({tag, "_one"}, sdram_draw, 1'b0);
      chk({tag, "_hold"}, {bitmap_intensity, sdram_x, sdram_y}, {i, x, y});
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk) chk_zero("reset");
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk) chk_zero("post_reset");

      grab(10'd5, 10'd10, 1'b0);
      @(negedge clk) chk("t28_rd", mem_read, 1'b1);
      chk("t28_addr", mem_address, {10'd5, 9'd5});
      db = draw_cnt;
      mem_serve(2, 16'hAB12);
      expect_draw("t28", 8'h12, 10'd10, 10'd5);
      chk("t28_ndraw", draw_cnt - db, 1);

      rb = rd_cnt;
`ifdef BITMAP_RESP_CACHE_EN
      grab(10'd5, 10'd11, 1'b0);
      expect_draw("t29", 8'hAB, 10'd11, 10'd5);
      chk("t29_nord", rd_cnt - rb, 0);
`else
      grab(10'd5, 10'd11, 1'b0);
      @(negedge clk) chk("t29_rd", mem_read, 1'b1);
      chk("t29_addr", mem_address, {10'd5, 9'd5});
      mem_serve(0, 16'hAB12);
      expect_draw("t29", 8'hAB, 10'd11, 10'd5);
`endif

      rb = rd_cnt;
      grab(10'd480, 10'd0, 1'b0);
      expect_draw("t30y", 8'h00, 10'd0, 10'd480);
      grab(10'd0, 10'd640, 1'b0);
      expect_draw("t30x", 8'h00, 10'd640, 10'd0);
      chk("t30_nord", rd_cnt - rb, 0);
      chk("t30_ovr", overrun, 1'b0);

      db = draw_cnt;
      sdram_addr = {3'b000, 10'd5, 10'd20};
      sdram_grab = 1'b1;
      @(posedge clk);
      @(negedge clk) chk("t31_ovr_pre", overrun, 1'b0);
      chk("t31_addr", mem_address, {10'd5, 9'd10});
      mem_serve(1, 16'h3C5A);
      sdram_grab = 1'b0;
      expect_draw("t31", 8'h5A, 10'd20, 10'd5);
      repeat (3) @(negedge clk);
      chk("t31_ndraw", draw_cnt - db, 1);
      chk("t31_ovr", overrun, 1'b1);

      grab(10'd5, 10'd21, 1'b1);
      @(negedge clk) chk("t33_rd", mem_read, 1'b1);
      chk("t33_addr", mem_address, {10'd5, 9'd10});
      mem_serve(0, 16'h7788);
      expect_draw("t33", 8'h77, 10'd21, 10'd5);
      rb = rd_cnt;
      grab(10'd5, 10'd20, 1'b0);
`ifdef BITMAP_RESP_CACHE_EN
      expect_draw("t33h", 8'h88, 10'd20, 10'd5);
      chk("t33h_nord", rd_cnt - rb, 0);
`else
      @(negedge clk) chk("t33m_rd", mem_read, 1'b1);
      mem_serve(0, 16'h7788);
      expect_draw("t33m", 8'h88, 10'd20, 10'd5);
`endif
      chk("ovr_sticky", overrun, 1'b1);

      grab(10'd100, 10'd200, 1'b0);
      @(negedge clk) chk("t32_rd", mem_read, 1'b1);
      @(posedge clk);
      #1 mem_waitrequest = 1'b0;
      @(posedge clk);
      #1 mem_waitrequest = 1'b1;
      @(negedge clk) chk("t32_wait", mem_read, 1'b0);
      db = draw_cnt;
      reset_n = 1'b0;
      #1 chk_zero("t32_async");
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1 mem_readdatavalid = 1'b1;
      mem_readdata = 16'hFFFF;
      @(posedge clk);
      #1 mem_readdatavalid = 1'b0;
      repeat (4) @(negedge clk);
      chk("t32_nodraw", draw_cnt - db, 0);
      chk_zero("t32_zero");
      grab(10'd1, 10'd2, 1'b0);
      @(negedge clk) chk("t32_idle_rd", mem_read, 1'b1);
      chk("t32_idle_addr", mem_address, {10'd1, 9'd1});
      mem_serve(0, 16'h1234);
      expect_draw("t32n", 8'h34, 10'd2, 10'd1);
      chk("t32_ovr", overrun, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/bitmap_responder.md
BITMAP_RESPONDER -- requirements
Module: bitmap_responder

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-002 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port sdram_grab  in  1  pixel request from VGA interface; sampled high = request.
REQ-004 SHALL have port sdram_addr  in  23  request address, format {3'b0, y[9:0], x[9:0]}; bits 22:20 ignored.
REQ-005 SHALL have port sdram_draw  out  1  one-cycle response strobe.
REQ-006 SHALL have port bitmap_intensity  out  8  pixel intensity, valid when sdram_draw=1 and held afterwards.
REQ-007 SHALL have ports sdram_x / sdram_y  out  10 each  coordinates of the response, valid and held like bitmap_intensity.
REQ-008 SHALL have ports mem_read out 1, mem_address out 19, mem_waitrequest in 1, mem_readdata in 16, mem_readdatavalid in 1: Avalon-MM read master to frame store.
REQ-009 SHALL have port cache_flush  in  1  one-cycle pulse at frame rewrite; invalidates word cache.
REQ-010 SHALL have port overrun  out  1  sticky flag, set when a request is dropped.

Function
REQ-011 SHALL implement states IDLE, REQ, WAIT, RESP.
REQ-012 SHALL accept a request only in IDLE with sdram_grab=1, capturing x=addr[9:0], y=addr[19:10] that edge.
REQ-013 SHALL treat sdram_grab=1 in REQ, WAIT or RESP as dropped: no response, overrun set to 1.
REQ-014 SHALL, for x>=640 or y>=480, go IDLE->RESP with intensity 8'h00 and no memory access.
REQ-015 SHALL, on cache hit (cache valid and tag {y,x[9:1]} matches), go IDLE->RESP with no memory access.
REQ-016 SHALL, on miss, go IDLE->REQ with mem_read=1, mem_address={y,x[9:1]}; mem_read and mem_address held stable until an edge with mem_waitrequest=0, then enter WAIT with mem_read=0.
REQ-017 SHALL in WAIT capture mem_readdata on mem_readdatavalid=1, load cache (tag, data, valid=1), enter RESP.
REQ-018 SHALL select byte mem_readdata[7:0] when x[0]=0, [15:8] when x[0]=1; same rule for cache data.
REQ-019 SHALL in RESP assert sdram_draw=1 for exactly one cycle with intensity, sdram_x, sdram_y updated that cycle, then return to IDLE.
REQ-020 SHALL give latency: grab sampled at edge N, hit/out-of-range -> sdram_draw high in cycle after edge N+1; miss -> sdram_draw high in cycle after the edge following the readdatavalid edge.
REQ-021 SHALL ignore mem_readdatavalid in any state other than WAIT.
REQ-022 SHALL clear cache valid on cache_flush; flush coinciding with an accepted request forces a miss.
REQ-023 SHALL leave one request in flight at most; new request accepted only after RESP.

Reset
REQ-024 SHALL on reset_n=0 force IDLE, sdram_draw=0, bitmap_intensity=0, sdram_x=0, sdram_y=0, mem_read=0, mem_address=0, overrun=0, cache valid=0.
REQ-025 SHALL abandon any in-flight read on reset; a readdatavalid arriving after reset release is ignored per REQ-021.
REQ-026 SHALL release reset without glitching mem_read or sdram_draw.

Configuration
REQ-027 SHALL compile the one-word cache only when BITMAP_RESP_CACHE_EN is defined; without it every in-range request is a miss, cache_flush is ignored, and REQ-015/REQ-022 do not apply.

Verification
REQ-028 SHALL cover: reset, grab addr {y=5,x=10}, waitrequest 2 cycles, readdatavalid data 16'hAB12 -> one sdram_draw, intensity 8'h12, x=10, y=5, mem_address={5,5}.
REQ-029 SHALL cover: after REQ-028, grab {y=5,x=11} -> with BITMAP_RESP_CACHE_EN draw one cycle after accept, intensity 8'hAB, no mem_read; without it a memory read issues.
REQ-030 SHALL cover: grab {y=480,x=0} and {y=0,x=640} -> draw with intensity 8'h00, mem_read never asserted.
REQ-031 SHALL cover: grab held high during WAIT -> overrun=1, exactly one draw; overrun stays 1 until reset.
REQ-032 SHALL cover: reset_n pulsed low in WAIT, then stray readdatavalid -> no draw, outputs zero, state IDLE.
REQ-033 SHALL cover: cache_flush same edge as grab to cached word -> miss, mem_read asserted.
